keypad_scan_debounce: RTL and testbench

Drives the 4x4 key-matrix rows, samples the columns, debounces all 16 keys and presents a stable 16-bit key map plus a press/release event stream. Sits directly upstream of the Cortex-M3 EMPU. `key_state` feeds `gpioin[15:0]`, and the event port feeds firmware polling or a future interrupt path. Replaces raw per-row copying of `KeyX` into GPIO.

---
 rtl/keypad_pkg.sv | 24 ++
 rtl/keypad_evt_fifo.sv | 54 +++++
 rtl/keypad_scan_debounce.sv | 132 +++++++++++++
 tb/tb_keypad_scan_debounce.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared widths, constants and the event record for the keypad scanner and its event FIFO.
package keypad_pkg;

  localparam int KEY_ROWS       = 4;
  localparam int KEY_COLS       = 4;
  localparam int KEY_NUM        = 16;
  localparam int EVT_W          = 5;
  localparam int EVT_PRESS_BIT  = 4;
  localparam int EVT_FIFO_DEPTH = 4;

  typedef struct packed {
    logic       press;
    logic [3:0] idx;
  } evt_t;

  function automatic evt_t make_evt(input logic press, input logic [3:0] idx);
    logic [EVT_W-1:0] r;
    r = '0;
    r[EVT_PRESS_BIT] = press;
    r[EVT_PRESS_BIT-1:0] = idx;
    return evt_t'(r);
  endfunction

endpackage

// File: rtl/keypad_evt_fifo.sv
// 4x5 register FIFO for key events; head is registered storage muxed by the read pointer.
// Pops while empty are ignored; a push while full without a pop is dropped and flagged on drop.
module keypad_evt_fifo
  import keypad_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  evt_t push_dat,
  input  logic pop,
  output evt_t head,
  output logic empty,
  output logic drop
);

  localparam int PTR_W = $clog2(EVT_FIFO_DEPTH);

  evt_t             mem [EVT_FIFO_DEPTH];
  logic [PTR_W-1:0] wp;
  logic [PTR_W-1:0] rp;
  logic [PTR_W:0]   cnt;
  logic             full;
  logic             do_pop;
  logic             do_push;

  assign empty   = (cnt == '0);
  assign full    = (cnt == (PTR_W+1)'(EVT_FIFO_DEPTH));
  assign do_pop  = pop && !empty;
  // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
  assign do_push = push && (!full || do_pop);
  assign drop    = push && full && !do_pop;
  assign head    = mem[rp];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
      for (int i = 0; i < EVT_FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wp] <= push_dat;
        wp      <= wp + 1'b1;
      end
      if (do_pop) rp <= rp + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/keypad_scan_debounce.sv
// 4x4 matrix scanner: row drive, column sync, per-key debounce, event FIFO; state flips DEBOUNCE_CNT samples after change.
// Event consumer pops with evt_ready; events arriving while the FIFO is full are dropped and latched in evt_ovf.
module keypad_scan_debounce
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV     = 100,
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic                gclk,
  input  logic                gresetn,
  input  logic [KEY_COLS-1:0] KeyX,
  output logic [KEY_ROWS-1:0] KeyY,
  output logic [KEY_NUM-1:0]  key_state,
  output logic                key_any,
  output logic                evt_valid,
  output logic [EVT_W-1:0]    evt_code,
  input  logic                evt_ready,
  output logic                evt_ovf,
  input  logic                ovf_clr
);

  localparam int                PC_W    = $clog2(SCAN_DIV);
  localparam int                ROW_W   = $clog2(KEY_ROWS);
  localparam logic [PC_W-1:0]   PC_LAST = PC_W'(SCAN_DIV - 1);
  localparam logic [3:0]        DC_LAST = 4'(DEBOUNCE_CNT - 1);

  logic [KEY_COLS-1:0] kx_m;
  logic [KEY_COLS-1:0] kx_s;
  logic [PC_W-1:0]     pc;
  logic [ROW_W-1:0]    row;
  logic [ROW_W-1:0]    samp_row;
  logic [KEY_COLS-1:0] samp;
  logic                samp_vld;
  logic                first_done;
  logic [3:0]          dc [KEY_NUM];

  logic                upd;
  logic [1:0]          col;
  logic [3:0]          k;
  logic                bit_s;
  logic                dc_clr;
  logic                dc_inc;
  logic                flip;
  evt_t                evt;
  evt_t                fifo_head;
  logic                fifo_empty;
  logic                fifo_drop;

  always_ff @(posedge gclk) begin
    if (!gresetn) begin
      kx_m <= '0;
      kx_s <= '0;
    end else begin
      kx_m <= KeyX;
      kx_s <= kx_m;
    end
  end

  // The first latched sample may predate a settled synchronizer, so it is never processed.
  always_ff @(posedge gclk) begin
    if (!gresetn) begin
      pc         <= '0;
      row        <= '0;
      samp       <= '0;
      samp_row   <= '0;
      samp_vld   <= 1'b0;
      first_done <= 1'b0;
    end else if (pc == PC_LAST) begin
      pc         <= '0;
      row        <= row + 1'b1;
      samp       <= kx_s;
      samp_row   <= row;
      samp_vld   <= first_done;
      first_done <= 1'b1;
    end else begin
      pc <= pc + 1'b1;
    end
  end

  assign KeyY  = KEY_ROWS'(1) << row;
  assign upd   = samp_vld && (int'(pc) < KEY_COLS);
  assign col   = pc[1:0];
  assign k     = {samp_row, col};
  assign bit_s = samp[col];

  always_comb begin
    dc_clr = 1'b0;
    dc_inc = 1'b0;
    flip   = 1'b0;
    if (upd) begin
      if (bit_s == key_state[k])  dc_clr = 1'b1;
      else if (dc[k] == DC_LAST)  flip   = 1'b1;
      else                        dc_inc = 1'b1;
    end
  end

  always_ff @(posedge gclk) begin
    if (!gresetn) begin
      key_state <= '0;
      for (int i = 0; i < KEY_NUM; i++) dc[i] <= '0;
    end else begin
      if (dc_clr || flip) dc[k] <= '0;
      else if (dc_inc)    dc[k] <= dc[k] + 1'b1;
      if (flip) key_state[k] <= bit_s;
    end
  end

  assign evt = make_evt(bit_s, k);

  keypad_evt_fifo u_fifo (
    .clk      (gclk),
    .rst_n    (gresetn),
    .push     (flip),
    .push_dat (evt),
    .pop      (evt_valid && evt_ready),
    .head     (fifo_head),
    .empty    (fifo_empty),
    .drop     (fifo_drop)
  );

  assign evt_valid = !fifo_empty;
  assign evt_code  = fifo_head;
  assign key_any   = |key_state;

  // A drop in the same cycle as a clear keeps the flag set.
  always_ff @(posedge gclk) begin
    if (!gresetn)       evt_ovf <= 1'b0;
    else if (fifo_drop) evt_ovf <= 1'b1;
    else if (ovf_clr)   evt_ovf <= 1'b0;
  end

endmodule

// File: tb/tb_keypad_scan_debounce.sv
// Directed bench for keypad_scan_debounce (SCAN_DIV=8, DEBOUNCE_CNT=2) with an event scoreboard.
module tb_keypad_scan_debounce;

  logic        gclk;
  logic        gresetn;
  logic [3:0]  KeyX;
  logic [3:0]  KeyY;
  logic [15:0] key_state;
  logic        key_any;
  logic        evt_valid;
  logic [4:0]  evt_code;
  logic        evt_ready;
  logic        evt_ovf;
  logic        ovf_clr;

  logic [15:0] pressed;
  logic        x_ovr;
  logic [4:0]  sb[$];
  int          pop_times[$];
  int          cyc;
  int          n_cmp;
  int          n_bad;

  keypad_scan_debounce #(.SCAN_DIV(8), .DEBOUNCE_CNT(2)) dut (
    .gclk      (gclk),
    .gresetn   (gresetn),
    .KeyX      (KeyX),
    .KeyY      (KeyY),
    .key_state (key_state),
    .key_any   (key_any),
    .evt_valid (evt_valid),
    .evt_code  (evt_code),
    .evt_ready (evt_ready),
    .evt_ovf   (evt_ovf),
    .ovf_clr   (ovf_clr)
  );

  initial gclk = 1'b0;
  always #5 gclk = ~gclk;

  initial cyc = 0;
  always @(posedge gclk) cyc <= cyc + 1;

  // Key matrix: a pressed key connects its row drive to its column.
  always_comb begin
    KeyX = 4'h0;
    if (x_ovr) KeyX = 4'hF;
    else
      for (int r = 0; r < 4; r++)
        if (KeyY[r]) KeyX = KeyX | pressed[4*r +: 4];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc_n(input int n);
    repeat (n) @(negedge gclk);
  endtask

  task automatic wait_row_start(input int r);
    logic [3:0] prev;
    logic       found;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      prev = KeyY;
      @(negedge gclk);
      if (KeyY != prev && KeyY == (4'b0001 << r)) found = 1'b1;
    end
    check($sformatf("row_start_%0d", r), {31'b0, found}, 32'd1);
  endtask

  // Every pop is checked against the oldest outstanding expected event.
  always begin
    logic have;
    @(negedge gclk);
    #1;
    if (gresetn && evt_valid && evt_ready) begin
      pop_times.push_back(cyc);
      have = (sb.size() != 0);
      check("evt_expected", {31'b0, have}, 32'd1);
      if (have) check("evt_code", {27'b0, evt_code}, {27'b0, sb.pop_front()});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int span;
    n_cmp     = 0;
    n_bad     = 0;
    gresetn   = 1'b0;
    x_ovr     = 1'b1;
    pressed   = '0;
    evt_ready = 1'b0;
    ovf_clr   = 1'b0;

    // 1. Reset values and row sequence
    repeat (3) @(negedge gclk);
    check("rst_keyy", KeyY, 4'b0001);
    check("rst_state", key_state, 16'h0);
    check("rst_any", key_any, 1'b0);
    check("rst_valid", evt_valid, 1'b0);
    check("rst_code", evt_code, 5'h0);
    check("rst_ovf", evt_ovf, 1'b0);
    x_ovr   = 1'b0;
    gresetn = 1'b1;
    for (int i = 0; i < 32; i++) begin
      check($sformatf("keyy_seq_%0d", i), KeyY, 32'd1 << (i / 8));
      @(negedge gclk);
    end

    // 2. Single press and release of key 5
    evt_ready = 1'b1;
    pressed   = 16'h0020;
    sb.push_back(5'h15);
    cyc_n(96);
    check("press_state", key_state, 16'h0020);
    check("press_any", key_any, 1'b1);
    check("press_sb_empty", sb.size(), 0);
    wait_row_start(1);
    pressed = 16'h0;
    sb.push_back(5'h05);
    cyc_n(41);
    check("release_before", key_state, 16'h0020);
    cyc_n(1);
    check("release_state", key_state, 16'h0);
    check("release_any", key_any, 1'b0);
    check("release_valid", evt_valid, 1'b1);
    cyc_n(4);
    check("release_sb_empty", sb.size(), 0);
    check("release_drained", evt_valid, 1'b0);

    // 3. Bounce: key 5 seen in exactly one sample
    wait_row_start(1);
    pressed = 16'h0020;
    cyc_n(16);
    pressed = 16'h0;
    cyc_n(96);
    check("bounce_state", key_state, 16'h0);
    check("bounce_valid", evt_valid, 1'b0);
    check("bounce_sb_empty", sb.size(), 0);

    // 4. Row 2 burst
    pop_times.delete();
    pressed = 16'h0F00;
    sb.push_back(5'h18); sb.push_back(5'h19); sb.push_back(5'h1A); sb.push_back(5'h1B);
    cyc_n(96);
    check("burst_state", key_state, 16'h0F00);
    check("burst_sb_empty", sb.size(), 0);
    check("burst_pops", pop_times.size(), 4);
    span = (pop_times.size() == 4) ? (pop_times[3] - pop_times[0]) : -1;
    check("burst_consecutive", span, 3);
    pressed = 16'h0;
    sb.push_back(5'h08); sb.push_back(5'h09); sb.push_back(5'h0A); sb.push_back(5'h0B);
    cyc_n(96);
    check("burst_rel_state", key_state, 16'h0);
    check("burst_rel_sb_empty", sb.size(), 0);

    // 5. Overflow: five presses with no consumer
    evt_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      pressed[i] = 1'b1;
      if (i < 4) sb.push_back({1'b1, 4'(i)});
      cyc_n(96);
      if (i == 3) check("ovf_not_yet", evt_ovf, 1'b0);
    end
    check("ovf_set", evt_ovf, 1'b1);
    check("ovf_state", key_state, 16'h001F);
    check("ovf_head", evt_code, 5'h10);
    wait_row_start(1);
    pressed[4] = 1'b0;
    cyc_n(40);
    ovf_clr = 1'b1;
    cyc_n(1);
    ovf_clr = 1'b0;
    check("ovf_set_wins", evt_ovf, 1'b1);
    check("ovf_drop_state", key_state, 16'h000F);
    ovf_clr = 1'b1;
    cyc_n(1);
    ovf_clr = 1'b0;
    check("ovf_cleared", evt_ovf, 1'b0);

    // 6. Push and pop together while full, then reset mid-update
    wait_row_start(0);
    pressed = 16'h0007;
    sb.push_back(5'h03);
    cyc_n(43);
    evt_ready = 1'b1;
    cyc_n(1);
    evt_ready = 1'b0;
    check("full_pp_ovf", evt_ovf, 1'b0);
    check("full_pp_head", evt_code, 5'h11);
    check("full_pp_state", key_state, 16'h0007);
    evt_ready = 1'b1;
    cyc_n(8);
    check("full_pp_sb_empty", sb.size(), 0);
    check("full_pp_drained", evt_valid, 1'b0);

    evt_ready = 1'b0;
    pressed   = 16'h0006;
    cyc_n(96);
    check("pre_rst_valid", evt_valid, 1'b1);
    check("pre_rst_state", key_state, 16'h0006);
    wait_row_start(2);
    cyc_n(1);
    gresetn = 1'b0;
    cyc_n(1);
    check("mid_rst_keyy", KeyY, 4'b0001);
    check("mid_rst_state", key_state, 16'h0);
    check("mid_rst_any", key_any, 1'b0);
    check("mid_rst_valid", evt_valid, 1'b0);
    check("mid_rst_code", evt_code, 5'h0);
    check("mid_rst_ovf", evt_ovf, 1'b0);
    gresetn   = 1'b1;
    evt_ready = 1'b1;
    sb.push_back(5'h11);
    sb.push_back(5'h12);
    cyc_n(60);
    check("held_not_yet", key_state, 16'h0);
    check("held_no_evt", evt_valid, 1'b0);
    cyc_n(60);
    check("held_state", key_state, 16'h0006);
    check("held_sb_empty", sb.size(), 0);

    pressed = 16'h0;
    sb.push_back(5'h01);
    sb.push_back(5'h02);
    cyc_n(120);
    check("final_state", key_state, 16'h0);
    check("final_sb_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
